// File: rtl/distribute1to3.sv
// -----------------------------------------------------------------------------
// distribute1to3
//
// Purpose
//   Routes one N-bit operand stream (a GF(2^233) field element by default) to
//   one of three destination buffers, A, B or C, chosen by SEL.
//   Each destination is a one-entry skid-free buffer: an N-bit data register
//   plus a valid flag. The three buffers drain independently of each other.
//
// Handshake (identical on every channel)
//   A transfer happens on a rising CLK edge where VALID && READY are both high.
//   A producer holds VALID and its data steady until that transfer happens.
//   READY may be sampled combinationally. IN_READY depends on SEL and on the
//   downstream *_READY of the selected buffer, but never on IN_VALID.
//
// Ports
//   CLK                        system clock, rising edge active
//   RST_N                      synchronous reset, active low
//   SEL[1:0]                   destination: 00 -> C, 01 -> B, 1x -> A
//   IN[N-1:0], IN_VALID        source operand and its valid
//   IN_READY                   source operand accepted this cycle
//   A/B/C[N-1:0]               registered destination operands
//   A/B/C_VALID                destination holds an undelivered operand
//   A/B/C_READY                downstream takes the destination operand
// -----------------------------------------------------------------------------
module distribute1to3 #(
    parameter int N = 233
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [1:0]   SEL,
    input  logic [N-1:0] IN,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [N-1:0] C,
    output logic         A_VALID,
    output logic         B_VALID,
    output logic         C_VALID,
    input  logic         A_READY,
    input  logic         B_READY,
    input  logic         C_READY
);

    // Destination decode.
    logic sel_a;
    logic sel_b;
    logic sel_c;

    // Output transfer on each buffer this cycle.
    logic a_take;
    logic b_take;
    logic c_take;

    // Buffer can accept a new operand this cycle: either empty, or its
    // current operand leaves on this same edge (back-to-back, no bubble).
    logic a_free;
    logic b_free;
    logic c_free;

    // Input transfer, and which buffer it lands in.
    logic in_fire;
    logic a_load;
    logic b_load;
    logic c_load;

    always_comb begin
        sel_a    = SEL[1];            // 10 and 11 both target A
        sel_b    = (SEL == 2'b01);
        sel_c    = (SEL == 2'b00);

        a_take   = A_VALID && A_READY;
        b_take   = B_VALID && B_READY;
        c_take   = C_VALID && C_READY;

        a_free   = !A_VALID || A_READY;
        b_free   = !B_VALID || B_READY;
        c_free   = !C_VALID || C_READY;

        // Held low during reset so no operand is ever taken and then dropped.
        IN_READY = RST_N && ((sel_a && a_free) ||
                             (sel_b && b_free) ||
                             (sel_c && c_free));

        in_fire  = IN_VALID && IN_READY;
        a_load   = in_fire && sel_a;
        b_load   = in_fire && sel_b;
        c_load   = in_fire && sel_c;
    end

    // Buffer A. A load wins over a take: the valid flag stays set and the
    // register picks up the new operand. A take alone only clears the flag;
    // the data register keeps its last value.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            A       <= '0;
            A_VALID <= 1'b0;
        end else if (a_load) begin
            A       <= IN;
            A_VALID <= 1'b1;
        end else if (a_take) begin
            A_VALID <= 1'b0;
        end
    end

    // Buffer B, same behaviour as A.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            B       <= '0;
            B_VALID <= 1'b0;
        end else if (b_load) begin
            B       <= IN;
            B_VALID <= 1'b1;
        end else if (b_take) begin
            B_VALID <= 1'b0;
        end
    end

    // Buffer C, same behaviour as A.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            C       <= '0;
            C_VALID <= 1'b0;
        end else if (c_load) begin
            C       <= IN;
            C_VALID <= 1'b1;
        end else if (c_take) begin
            C_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_distribute1to3.sv
// -----------------------------------------------------------------------------
// tb_distribute1to3
//
// Directed and random stimulus for distribute1to3. Inputs change on the
// falling edge; handshakes and outputs are observed 1 time unit later, well
// before the next rising edge. Each accepted operand is pushed to the queue of
// its destination; each delivered operand is popped and compared.
// -----------------------------------------------------------------------------
module tb_distribute1to3;

    localparam int N = 233;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   sel;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a, b, c;
    logic         a_valid, b_valid, c_valid;
    logic         a_ready, b_ready, c_ready;

    distribute1to3 #(.N(N)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .SEL      (sel),
        .IN       (in_data),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .A        (a),
        .B        (b),
        .C        (c),
        .A_VALID  (a_valid),
        .B_VALID  (b_valid),
        .C_VALID  (c_valid),
        .A_READY  (a_ready),
        .B_READY  (b_ready),
        .C_READY  (c_ready)
    );

    // ---------------- scoreboard ----------------
    logic [N-1:0] exp_a[$];
    logic [N-1:0] exp_b[$];
    logic [N-1:0] exp_c[$];

    int total = 0;
    int bad   = 0;
    int sent_cnt = 0;
    int recv_cnt = 0;
    int ones_seen = 0;
    bit accepted;

    logic [N-1:0] all_ones;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input int which, input logic [N-1:0] got);
        logic [N-1:0] exp;
        int           sz;
        case (which)
            0:       sz = exp_a.size();
            1:       sz = exp_b.size();
            default: sz = exp_c.size();
        endcase
        chk($sformatf("sb_nonempty_%0d", which), N'(sz != 0), N'(1));
        if (sz != 0) begin
            case (which)
                0:       exp = exp_a.pop_front();
                1:       exp = exp_b.pop_front();
                default: exp = exp_c.pop_front();
            endcase
            chk($sformatf("sb_data_%0d", which), got, exp);
            recv_cnt++;
            if (got === all_ones && exp === all_ones) ones_seen++;
        end
    endtask

    // One clock cycle: observe handshakes with the current inputs, then
    // advance to the next falling edge.
    task automatic cycle();
        bit was_rst;
        #1;
        was_rst  = !rst_n;
        accepted = 1'b0;
        if (was_rst) begin
            chk("rst_in_ready", N'(in_ready), N'(0));
        end else begin
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                sent_cnt++;
                case (sel)
                    2'b00:   exp_c.push_back(in_data);
                    2'b01:   exp_b.push_back(in_data);
                    default: exp_a.push_back(in_data);
                endcase
            end
            if (a_valid && a_ready) pop_check(0, a);
            if (b_valid && b_ready) pop_check(1, b);
            if (c_valid && c_ready) pop_check(2, c);
        end
        @(posedge clk);
        @(negedge clk);
        if (was_rst) begin
            exp_a.delete();
            exp_b.delete();
            exp_c.delete();
        end
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[N-1:0];
    endfunction

    task automatic check_empty_state(input string tag);
        chk({tag, "_a"}, a, '0);
        chk({tag, "_b"}, b, '0);
        chk({tag, "_c"}, c, '0);
        chk({tag, "_av"}, N'(a_valid), N'(0));
        chk({tag, "_bv"}, N'(b_valid), N'(0));
        chk({tag, "_cv"}, N'(c_valid), N'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n_ops;
        int guard;

        all_ones = '1;
        rst_n    = 1'b0;
        sel      = 2'b01;
        in_data  = N'(8'hAA);
        in_valid = 1'b1;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        c_ready  = 1'b0;

        // Reset with a pending input: never accepted.
        cycle();
        cycle();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_empty_state("reset");

        // Routing: C<-1, B<-2, A<-3 (SEL=11).
        in_valid = 1'b1;
        sel = 2'b00; in_data = N'(1);
        #1 chk("route_rdy_c", N'(in_ready), N'(1));
        cycle();
        sel = 2'b01; in_data = N'(2);
        #1 chk("route_rdy_b", N'(in_ready), N'(1));
        cycle();
        sel = 2'b11; in_data = N'(3);
        #1 chk("route_rdy_a", N'(in_ready), N'(1));
        cycle();
        in_valid = 1'b0;
        #1;
        chk("route_c", c, N'(1));
        chk("route_b", b, N'(2));
        chk("route_a", a, N'(3));
        chk("route_valids", N'({a_valid, b_valid, c_valid}), N'(3'b111));

        // A is full and not draining: SEL=10 must be refused.
        sel = 2'b10; in_data = N'(4); in_valid = 1'b1;
        #1 chk("full_a_not_ready", N'(in_ready), N'(0));
        cycle();
        in_valid = 1'b0;
        #1 chk("full_a_holds", a, N'(3));

        // Drain B and C, then load 5 into B.
        b_ready = 1'b1; c_ready = 1'b1;
        cycle();
        b_ready = 1'b0; c_ready = 1'b0;
        sel = 2'b01; in_data = N'(5); in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;

        // Backpressure on B for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_b_data", b, N'(5));
            chk("bp_b_valid", N'(b_valid), N'(1));
            cycle();
        end
        sel = 2'b00;
        #1 chk("bp_c_empty_ready", N'(in_ready), N'(1));

        // Replace 5 with 7 (itself a pass-through), then 7 -> 9.
        b_ready = 1'b1; sel = 2'b01; in_data = N'(7); in_valid = 1'b1;
        cycle();
        in_data = N'(9);
        #1;
        chk("pt_ready", N'(in_ready), N'(1));
        chk("pt_b_before", b, N'(7));
        cycle();
        in_valid = 1'b0; b_ready = 1'b0;
        #1;
        chk("pt_b_after", b, N'(9));
        chk("pt_b_valid", N'(b_valid), N'(1));

        // Drain everything.
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        cycle();
        cycle();
        #1 chk("drain_valids", N'({a_valid, b_valid, c_valid}), N'(0));

        // Streaming: 100 accepted operands, random SEL / readies.
        n_ops = 0;
        guard = 0;
        sent_cnt = 0;
        recv_cnt = 0;
        while (n_ops < 100 && guard < 3000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            sel      = 2'($urandom_range(0, 3));
            in_data  = (n_ops == 37) ? all_ones : rand_word();
            a_ready  = ($urandom_range(0, 1) == 1);
            b_ready  = ($urandom_range(0, 1) == 1);
            c_ready  = ($urandom_range(0, 2) != 0);
            cycle();
            if (accepted) n_ops++;
            guard++;
        end
        chk("stream_no_timeout", N'(n_ops), N'(100));
        in_valid = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        cycle();
        cycle();
        chk("stream_q_empty", N'(exp_a.size() + exp_b.size() + exp_c.size()), N'(0));
        chk("stream_recv_cnt", N'(recv_cnt), N'(sent_cnt));
        chk("stream_all_ones", N'(ones_seen), N'(1));

        // Reset mid-operation with all three buffers full.
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        in_valid = 1'b1;
        sel = 2'b10; in_data = rand_word(); cycle();
        sel = 2'b01; in_data = rand_word(); cycle();
        sel = 2'b00; in_data = rand_word(); cycle();
        #1 chk("mid_full", N'({a_valid, b_valid, c_valid}), N'(3'b111));
        rst_n = 1'b0; sel = 2'b01; in_data = N'(16'hBEEF);
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        #1;
        check_empty_state("midrst");
        cycle();
        chk("midrst_still_empty", N'({a_valid, b_valid, c_valid}), N'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
